// File: rtl/us_interval_timer_pkg.sv
// Shared types and helpers for the microsecond interval timer.
package us_interval_timer_pkg;

   localparam int unsigned CNT_W_DEFAULT = 16;

   typedef enum logic [0:0] {
      TMR_IDLE = 1'b0,
      TMR_RUN  = 1'b1
   } TimerState_t;

   typedef struct packed {
      logic expire;
      logic irq;
      logic overrun;
   } timer_flags_t;

   // Sticky flag update: once set it stays set until explicitly cleared.
   function automatic logic sticky_set(input logic flag_q, input logic set_s);
      return flag_q | set_s;
   endfunction

endpackage

// File: rtl/us_interval_timer_if.sv
// Control/status bundle between a timer user (master) and the timer (slave).
interface us_interval_timer_if
   import us_interval_timer_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEFAULT
);
   logic             i_tick;
   logic             i_load;
   logic [CNT_W-1:0] i_period;
   logic             i_auto_reload;
   logic             i_stop;
   logic             i_irq_ack;
   logic             o_busy;
   logic [CNT_W-1:0] o_count;
   logic             o_expire;
   logic             o_irq;
   logic             o_overrun;

   modport master (
      output i_tick, i_load, i_period, i_auto_reload, i_stop, i_irq_ack,
      input  o_busy, o_count, o_expire, o_irq, o_overrun
   );

   modport slave (
      input  i_tick, i_load, i_period, i_auto_reload, i_stop, i_irq_ack,
      output o_busy, o_count, o_expire, o_irq, o_overrun
   );
endinterface

// File: rtl/us_interval_timer_tick_edge_det.sv
// Rising-edge detector for a strobe that is synchronous to i_clk.
// A level held high produces a single-cycle o_rise.
module tick_edge_det (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_sig,
   output logic o_rise
);
   logic sig_q;

   // Remember the previous sample of the strobe.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sig_q <= 1'b0;
      end else begin
         sig_q <= i_sig;
      end
   end

   assign o_rise = i_sig & ~sig_q;
endmodule

// File: rtl/us_interval_timer.sv
// Programmable microsecond interval timer. The 1 MHz divider output is
// treated as a tick strobe in the i_clk domain, never as a clock.
module us_interval_timer
   import us_interval_timer_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   us_interval_timer_if.slave   bus
);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   TimerState_t      state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             mode_q, mode_d;
   timer_flags_t     flags_q, flags_d;
   logic             tick_evt_s;
   logic             load_ok_s;
   logic             expire_evt_s;

   tick_edge_det u_tick_edge (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_sig   (bus.i_tick),
      .o_rise  (tick_evt_s)
   );

   // A zero-period load is treated as if no load happened at all.
   assign load_ok_s = bus.i_load & (bus.i_period != {CNT_W{1'b0}});

   // State, count, period and reload mode registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= TMR_IDLE;
         count_q  <= {CNT_W{1'b0}};
         period_q <= {CNT_W{1'b0}};
         mode_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         period_q <= period_d;
         mode_q   <= mode_d;
      end
   end

   // Next-state logic: load beats stop beats tick; count never goes below 1 while running.
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      period_d     = period_q;
      mode_d       = mode_q;
      expire_evt_s = 1'b0;
      case (state_q)
         TMR_IDLE: begin
            if (load_ok_s) begin
               count_d  = bus.i_period;
               period_d = bus.i_period;
               mode_d   = bus.i_auto_reload;
               state_d  = TMR_RUN;
            end else begin
               state_d  = TMR_IDLE;
            end
         end
         TMR_RUN: begin
            if (load_ok_s) begin
               count_d  = bus.i_period;
               period_d = bus.i_period;
               mode_d   = bus.i_auto_reload;
               state_d  = TMR_RUN;
            end else if (bus.i_stop) begin
               state_d  = TMR_IDLE;
            end else if (tick_evt_s) begin
               if (count_q == CNT_ONE) begin
                  expire_evt_s = 1'b1;
                  if (mode_q) begin
                     count_d = period_q;
                  end else begin
                     count_d = {CNT_W{1'b0}};
                     state_d = TMR_IDLE;
                  end
               end else begin
                  count_d = count_q - CNT_ONE;
               end
            end else begin
               state_d  = TMR_RUN;
            end
         end
         default: begin
            state_d = TMR_IDLE;
         end
      endcase
   end

   // Flag next-state: a new expiry wins over a coincident acknowledge.
   always_comb begin
      flags_d.expire = expire_evt_s;
      if (expire_evt_s) begin
         flags_d.irq     = 1'b1;
         flags_d.overrun = sticky_set(flags_q.overrun, flags_q.irq);
      end else if (bus.i_irq_ack) begin
         flags_d.irq     = 1'b0;
         flags_d.overrun = 1'b0;
      end else begin
         flags_d.irq     = flags_q.irq;
         flags_d.overrun = flags_q.overrun;
      end
   end

   // Registered expiry pulse and sticky status flags.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         flags_q <= '{expire: 1'b0, irq: 1'b0, overrun: 1'b0};
      end else begin
         flags_q <= flags_d;
      end
   end

   assign bus.o_busy    = (state_q == TMR_RUN);
   assign bus.o_count   = count_q;
   assign bus.o_expire  = flags_q.expire;
   assign bus.o_irq     = flags_q.irq;
   assign bus.o_overrun = flags_q.overrun;
endmodule

// File: tb/tb_us_interval_timer.sv
// Self-checking bench for us_interval_timer: directed scenarios plus a
// randomized run against a behavioural timer model.
module tb_us_interval_timer;
   localparam int CNT_W = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   us_interval_timer_if #(.CNT_W(CNT_W)) bus ();

   us_interval_timer #(.CNT_W(CNT_W)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Behavioural model: "running" timer with remaining microseconds.
   bit m_run, m_periodic, m_irq, m_ovr, m_exp, m_prev_tick;
   int m_rem, m_per;

   task automatic model_reset();
      m_run = 0; m_periodic = 0; m_irq = 0; m_ovr = 0; m_exp = 0;
      m_prev_tick = 0; m_rem = 0; m_per = 0;
   endtask

   // Advance the model by one clock using the currently applied inputs.
   task automatic model_clock();
      bit rise;
      int per;
      rise = bus.i_tick && !m_prev_tick;
      m_prev_tick = bus.i_tick;
      per = int'(bus.i_period);
      m_exp = 0;
      if (bus.i_load && per != 0) begin
         m_run = 1; m_rem = per; m_per = per; m_periodic = bus.i_auto_reload;
      end else if (bus.i_stop && m_run) begin
         m_run = 0;
      end else if (rise && m_run) begin
         if (m_rem == 1) begin
            m_exp = 1;
            if (m_irq) m_ovr = 1;
            m_irq = 1;
            if (m_periodic) m_rem = m_per;
            else begin m_rem = 0; m_run = 0; end
         end else begin
            m_rem = m_rem - 1;
         end
      end
      if (bus.i_irq_ack && !m_exp) begin
         m_irq = 0; m_ovr = 0;
      end
   endtask

   // Apply one cycle of inputs, clock it, and return at the following negedge.
   task automatic step(input bit load, input int per, input bit ar,
                       input bit stop, input bit tick, input bit ack);
      bus.i_load = load; bus.i_period = per[CNT_W-1:0]; bus.i_auto_reload = ar;
      bus.i_stop = stop; bus.i_tick = tick; bus.i_irq_ack = ack;
      @(posedge clk);
      model_clock();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      bus.i_load = 0; bus.i_period = '0; bus.i_auto_reload = 0;
      bus.i_stop = 0; bus.i_tick = 0; bus.i_irq_ack = 0;
      model_reset();
      repeat (3) @(negedge clk);
      total_cnt++; if (bus.o_busy !== 1'b0) $display("FAIL rst_busy got %0b exp 0", bus.o_busy); else pass_cnt++;
      total_cnt++; if (bus.o_count !== 16'd0) $display("FAIL rst_count got %0d exp 0", bus.o_count); else pass_cnt++;
      total_cnt++; if ({bus.o_expire, bus.o_irq, bus.o_overrun} !== 3'b000)
         $display("FAIL rst_flags got %b exp 000", {bus.o_expire, bus.o_irq, bus.o_overrun}); else pass_cnt++;
      rst_n = 1'b1;
      idle(2);
      total_cnt++; if (bus.o_busy !== 1'b0) $display("FAIL rst_release_busy got %0b exp 0", bus.o_busy); else pass_cnt++;
   endtask

   task automatic test_one_shot();
      step(1, 3, 0, 0, 0, 0);
      total_cnt++; if (bus.o_count !== 16'd3 || bus.o_busy !== 1'b1)
         $display("FAIL os_load got cnt=%0d busy=%0b exp cnt=3 busy=1", bus.o_count, bus.o_busy); else pass_cnt++;
      for (int k = 1; k <= 3; k++) begin
         step(0, 0, 0, 0, 1, 0);
         if (k < 3) begin
            total_cnt++; if (bus.o_count !== 16'(3 - k) || bus.o_expire !== 1'b0)
               $display("FAIL os_dec got cnt=%0d exp=%0b exp cnt=%0d exp=0", bus.o_count, bus.o_expire, 3 - k); else pass_cnt++;
         end else begin
            total_cnt++; if (bus.o_expire !== 1'b1) $display("FAIL os_expire got %0b exp 1", bus.o_expire); else pass_cnt++;
            total_cnt++; if (bus.o_irq !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_count !== 16'd0)
               $display("FAIL os_done got irq=%0b busy=%0b cnt=%0d exp irq=1 busy=0 cnt=0",
                        bus.o_irq, bus.o_busy, bus.o_count); else pass_cnt++;
         end
         for (int j = 0; j < 5; j++) begin
            step(0, 0, 0, 0, 0, 0);
            if (j == 0 && k == 3) begin
               total_cnt++; if (bus.o_expire !== 1'b0) $display("FAIL os_pulse_width got %0b exp 0", bus.o_expire); else pass_cnt++;
            end
         end
      end
   endtask

   task automatic test_periodic();
      int n_exp;
      n_exp = 0;
      step(0, 0, 0, 0, 0, 1);
      total_cnt++; if (bus.o_irq !== 1'b0 || bus.o_overrun !== 1'b0)
         $display("FAIL per_ack got irq=%0b ovr=%0b exp 0 0", bus.o_irq, bus.o_overrun); else pass_cnt++;
      step(1, 2, 1, 0, 0, 0);
      for (int t = 1; t <= 6; t++) begin
         step(0, 0, 0, 0, 1, 0);
         if (bus.o_expire === 1'b1) n_exp++;
         if (t == 2) begin
            total_cnt++; if (bus.o_irq !== 1'b1 || bus.o_overrun !== 1'b0 || bus.o_count !== 16'd2)
               $display("FAIL per_first got irq=%0b ovr=%0b cnt=%0d exp 1 0 2", bus.o_irq, bus.o_overrun, bus.o_count); else pass_cnt++;
         end
         if (t == 4) begin
            total_cnt++; if (bus.o_overrun !== 1'b1 || bus.o_count !== 16'd2)
               $display("FAIL per_overrun got ovr=%0b cnt=%0d exp 1 2", bus.o_overrun, bus.o_count); else pass_cnt++;
         end
         for (int j = 0; j < 5; j++) begin
            step(0, 0, 0, 0, 0, 0);
            if (bus.o_expire === 1'b1) n_exp++;
         end
      end
      total_cnt++; if (n_exp != 3) $display("FAIL per_pulses got %0d exp 3", n_exp); else pass_cnt++;
      total_cnt++; if (bus.o_busy !== 1'b1 || bus.o_irq !== 1'b1)
         $display("FAIL per_state got busy=%0b irq=%0b exp 1 1", bus.o_busy, bus.o_irq); else pass_cnt++;
   endtask

   task automatic test_ack_race();
      step(0, 0, 0, 0, 0, 1);
      total_cnt++; if (bus.o_irq !== 1'b0 || bus.o_overrun !== 1'b0)
         $display("FAIL race_clear got irq=%0b ovr=%0b exp 0 0", bus.o_irq, bus.o_overrun); else pass_cnt++;
      step(0, 0, 0, 0, 1, 0); idle(5);
      step(0, 0, 0, 0, 1, 0);
      total_cnt++; if (bus.o_expire !== 1'b1 || bus.o_irq !== 1'b1 || bus.o_overrun !== 1'b0)
         $display("FAIL race_plain got exp=%0b irq=%0b ovr=%0b exp 1 1 0", bus.o_expire, bus.o_irq, bus.o_overrun); else pass_cnt++;
      idle(5);
      step(0, 0, 0, 0, 1, 0); idle(5);
      step(0, 0, 0, 0, 1, 1);
      total_cnt++; if (bus.o_expire !== 1'b1 || bus.o_irq !== 1'b1 || bus.o_overrun !== 1'b1)
         $display("FAIL race_setwins got exp=%0b irq=%0b ovr=%0b exp 1 1 1", bus.o_expire, bus.o_irq, bus.o_overrun); else pass_cnt++;
      idle(1);
      step(0, 0, 0, 0, 0, 1);
      total_cnt++; if (bus.o_irq !== 1'b0 || bus.o_overrun !== 1'b0)
         $display("FAIL race_ack got irq=%0b ovr=%0b exp 0 0", bus.o_irq, bus.o_overrun); else pass_cnt++;
   endtask

   task automatic test_priority();
      step(1, 5, 0, 1, 1, 0);
      total_cnt++; if (bus.o_busy !== 1'b1 || bus.o_count !== 16'd5)
         $display("FAIL prio_load got busy=%0b cnt=%0d exp 1 5", bus.o_busy, bus.o_count); else pass_cnt++;
      idle(1);
      step(0, 0, 0, 1, 1, 0);
      total_cnt++; if (bus.o_busy !== 1'b0 || bus.o_count !== 16'd5)
         $display("FAIL prio_stop got busy=%0b cnt=%0d exp 0 5", bus.o_busy, bus.o_count); else pass_cnt++;
      idle(1); step(0, 0, 0, 0, 1, 0); idle(1);
      total_cnt++; if (bus.o_count !== 16'd5 || bus.o_busy !== 1'b0)
         $display("FAIL prio_idle_tick got cnt=%0d busy=%0b exp 5 0", bus.o_count, bus.o_busy); else pass_cnt++;
   endtask

   task automatic test_edge_cases();
      int n_exp;
      n_exp = 0;
      step(1, 0, 1, 0, 0, 0);
      if (bus.o_expire === 1'b1) n_exp++;
      total_cnt++; if (bus.o_busy !== 1'b0 || bus.o_count !== 16'd5)
         $display("FAIL edge_zero got busy=%0b cnt=%0d exp 0 5", bus.o_busy, bus.o_count); else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, i[0], 0);
         if (bus.o_expire === 1'b1) n_exp++;
      end
      total_cnt++; if (n_exp != 0) $display("FAIL edge_zero_expire got %0d exp 0", n_exp); else pass_cnt++;
      step(1, 3, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0);
      total_cnt++; if (bus.o_count !== 16'd2 || bus.o_busy !== 1'b1)
         $display("FAIL edge_held_tick got cnt=%0d busy=%0b exp 2 1", bus.o_count, bus.o_busy); else pass_cnt++;
   endtask

   task automatic test_random();
      int nfail_print;
      int r, per;
      nfail_print = 0;
      for (int c = 0; c < 3000; c++) begin
         r = $urandom_range(0, 9);
         if (r == 0) per = 0;
         else if (r < 8) per = $urandom_range(1, 6);
         else per = $urandom_range(1, 65535);
         step(($urandom_range(0, 39) == 0), per, $urandom_range(0, 1),
              ($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 7) == 0));
         total_cnt++;
         if (bus.o_count !== 16'(m_rem) || bus.o_busy !== m_run) begin
            if (nfail_print < 20) $display("FAIL rand_count cyc=%0d got cnt=%0d busy=%0b exp cnt=%0d busy=%0b",
                                           c, bus.o_count, bus.o_busy, m_rem, m_run);
            nfail_print++;
         end else pass_cnt++;
         total_cnt++;
         if ({bus.o_expire, bus.o_irq, bus.o_overrun} !== {m_exp, m_irq, m_ovr}) begin
            if (nfail_print < 20) $display("FAIL rand_flags cyc=%0d got %b exp %b",
                                           c, {bus.o_expire, bus.o_irq, bus.o_overrun}, {m_exp, m_irq, m_ovr});
            nfail_print++;
         end else pass_cnt++;
      end
   endtask

   task automatic test_mid_reset();
      step(1, 10, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      total_cnt++; if (bus.o_busy !== 1'b1 || bus.o_count !== 16'd9)
         $display("FAIL mrst_pre got busy=%0b cnt=%0d exp 1 9", bus.o_busy, bus.o_count); else pass_cnt++;
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      total_cnt++; if ({bus.o_busy, bus.o_count, bus.o_expire, bus.o_irq, bus.o_overrun} !== 20'd0)
         $display("FAIL mrst_async got busy=%0b cnt=%0d flags=%b exp all 0",
                  bus.o_busy, bus.o_count, {bus.o_expire, bus.o_irq, bus.o_overrun}); else pass_cnt++;
      @(negedge clk);
      bus.i_tick = 0;
      rst_n = 1'b1;
      step(0, 0, 0, 0, 1, 0);
      idle(1);
      total_cnt++; if (bus.o_busy !== 1'b0 || bus.o_count !== 16'd0)
         $display("FAIL mrst_after got busy=%0b cnt=%0d exp 0 0", bus.o_busy, bus.o_count); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_one_shot();
      test_periodic();
      test_ack_race();
      test_priority();
      test_edge_cases();
      test_random();
      test_mid_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
